// File: rtl/conv_seq.sv
// Sequencer for the 5x5 convolution datapath: loads kernels, then per output pixel loads the
// window and writes one result per output channel through the single DRAM port.
module conv_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18,
  parameter int KNL_DIM    = 5,
  parameter int KNL_MAXNUM = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [5:0]            num_knls,
  input  logic [5:0]            ifmap_w,
  input  logic                  first_chnl,
  input  logic [ADDR_WIDTH-1:0] knl_base,
  input  logic [ADDR_WIDTH-1:0] ifmap_base,
  input  logic [ADDR_WIDTH-1:0] ofmap_base,
  input  logic                  dram_valid,
  output logic [ADDR_WIDTH-1:0] addr_rd,
  output logic [ADDR_WIDTH-1:0] addr_wr,
  output logic                  dram_en_rd,
  output logic                  dram_en_wr,
  output logic                  en_ld_knl,
  output logic                  en_ld_ifmap,
  output logic                  disable_acc,
  output logic [4:0]            ochnl_idx,
  output logic                  busy,
  output logic                  done
);

  localparam int AW       = ADDR_WIDTH;
  localparam int KNL_SIZE = KNL_DIM * KNL_DIM;
  localparam logic [2:0] WIN_LAST = 3'(KNL_DIM - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KNL,
    S_WIN,
    S_OUT_WR,
    S_OUT_RD,
    S_FIN
  } state_t;

  state_t state, state_nxt;

  logic [5:0]    nk_q;
  logic [5:0]    w_q;
  logic [5:0]    wo_q;
  logic [AW-1:0] stride_q;
  logic          first_q;
  logic [AW-1:0] knl_base_q;
  logic [AW-1:0] ifmap_base_q;
  logic [AW-1:0] ofmap_base_q;
  logic [8:0]    n_q;
  logic [8:0]    n_last_q;
  logic [2:0]    win_r;
  logic [2:0]    win_c;
  logic [5:0]    ox_q;
  logic [5:0]    oy_q;

  logic          cfg_ok;
  logic          knl_last;
  logic          win_last;
  logic          k_last;
  logic          pix_last;
  logic          out_step;
  logic [2:0]    nx_r;
  logic [2:0]    nx_c;
  logic [5:0]    nx_ox;
  logic [5:0]    nx_oy;
  logic [5:0]    wo_in;
  logic [AW-1:0] win_nxt_addr;
  logic [AW-1:0] win_pix_addr;
  logic [AW-1:0] out_addr;
  logic [AW-1:0] out_nxt_addr;

  assign cfg_ok   = (num_knls != 6'd0) && (num_knls <= 6'(KNL_MAXNUM)) && (ifmap_w >= 6'(KNL_DIM));
  assign wo_in    = ifmap_w - 6'(KNL_DIM - 1);
  assign knl_last = (n_q == n_last_q);
  assign win_last = (win_c == WIN_LAST) && (win_r == WIN_LAST);
  assign k_last   = ({1'b0, ochnl_idx} == (nk_q - 6'd1));
  assign pix_last = (ox_q == (wo_q - 6'd1)) && (oy_q == (wo_q - 6'd1));
  assign out_step = (state == S_OUT_WR) || ((state == S_OUT_RD) && dram_valid);

  // Window walks column-major (row inner); pixels walk ox inner, oy outer.
  always_comb begin
    nx_r  = win_r + 3'd1;
    nx_c  = win_c;
    if (win_r == WIN_LAST) begin
      nx_r = '0;
      nx_c = win_c + 3'd1;
    end
    nx_ox = ox_q + 6'd1;
    nx_oy = oy_q;
    if (ox_q == (wo_q - 6'd1)) begin
      nx_ox = '0;
      nx_oy = oy_q + 6'd1;
    end
  end

  always_comb begin
    win_nxt_addr = ifmap_base_q + (AW'(oy_q) + AW'(nx_r)) * AW'(w_q) + AW'(ox_q) + AW'(nx_c);
    win_pix_addr = ifmap_base_q + AW'(nx_oy) * AW'(w_q) + AW'(nx_ox);
    out_addr     = ofmap_base_q + AW'(oy_q) * AW'(wo_q) + AW'(ox_q);
    out_nxt_addr = addr_wr + stride_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (start && cfg_ok) state_nxt = S_KNL;
      S_KNL:    if (dram_valid && knl_last) state_nxt = S_WIN;
      S_WIN:    if (dram_valid && win_last) state_nxt = first_q ? S_OUT_WR : S_OUT_RD;
      S_OUT_WR,
      S_OUT_RD: if (out_step && k_last) state_nxt = pix_last ? S_FIN : S_WIN;
      S_FIN:    state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // The read-modify-write write fires in the same cycle the partial sum returns.
  always_comb begin
    en_ld_knl   = (state == S_KNL) && dram_valid;
    en_ld_ifmap = (state == S_WIN) && dram_valid;
    dram_en_wr  = out_step;
    disable_acc = (state == S_OUT_WR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nk_q         <= '0;
      w_q          <= '0;
      wo_q         <= '0;
      stride_q     <= '0;
      first_q      <= 1'b0;
      knl_base_q   <= '0;
      ifmap_base_q <= '0;
      ofmap_base_q <= '0;
      n_q          <= '0;
      n_last_q     <= '0;
      win_r        <= '0;
      win_c        <= '0;
      ox_q         <= '0;
      oy_q         <= '0;
      addr_rd      <= '0;
      addr_wr      <= '0;
      dram_en_rd   <= 1'b0;
      ochnl_idx    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      dram_en_rd <= 1'b0;
      done       <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              nk_q         <= num_knls;
              w_q          <= ifmap_w;
              wo_q         <= wo_in;
              stride_q     <= AW'(wo_in) * AW'(wo_in);
              first_q      <= first_chnl;
              knl_base_q   <= knl_base;
              ifmap_base_q <= ifmap_base;
              ofmap_base_q <= ofmap_base;
              n_q          <= '0;
              n_last_q     <= 9'(num_knls) * 9'(KNL_SIZE) - 9'd1;
              win_r        <= '0;
              win_c        <= '0;
              ox_q         <= '0;
              oy_q         <= '0;
              ochnl_idx    <= '0;
              busy         <= 1'b1;
              dram_en_rd   <= 1'b1;
              addr_rd      <= knl_base;
            end else begin
              done <= 1'b1;
            end
          end
        end
        S_KNL: begin
          if (dram_valid) begin
            dram_en_rd <= 1'b1;
            if (knl_last) begin
              addr_rd <= ifmap_base_q;
            end else begin
              n_q     <= n_q + 9'd1;
              addr_rd <= knl_base_q + AW'(n_q) + AW'(1);
            end
          end
        end
        S_WIN: begin
          if (dram_valid) begin
            if (win_last) begin
              win_r     <= '0;
              win_c     <= '0;
              ochnl_idx <= '0;
              addr_wr   <= out_addr;
              if (!first_q) begin
                dram_en_rd <= 1'b1;
                addr_rd    <= out_addr;
              end
            end else begin
              win_r      <= nx_r;
              win_c      <= nx_c;
              dram_en_rd <= 1'b1;
              addr_rd    <= win_nxt_addr;
            end
          end
        end
        S_OUT_WR,
        S_OUT_RD: begin
          if (out_step) begin
            if (k_last) begin
              if (pix_last) begin
                busy <= 1'b0;
                done <= 1'b1;
              end else begin
                ox_q       <= nx_ox;
                oy_q       <= nx_oy;
                dram_en_rd <= 1'b1;
                addr_rd    <= win_pix_addr;
              end
            end else begin
              ochnl_idx <= ochnl_idx + 5'd1;
              addr_wr   <= out_nxt_addr;
              if (!first_q) begin
                dram_en_rd <= 1'b1;
                addr_rd    <= out_nxt_addr;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_seq.sv
// Directed bench for conv_seq: a DRAM responder with configurable latency plus per-scenario tasks.
module tb_conv_seq;
  localparam int AW = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [5:0]    num_knls;
  logic [5:0]    ifmap_w;
  logic          first_chnl;
  logic [AW-1:0] knl_base, ifmap_base, ofmap_base;
  logic          dram_valid;
  logic [AW-1:0] addr_rd, addr_wr;
  logic          dram_en_rd, dram_en_wr, en_ld_knl, en_ld_ifmap, disable_acc;
  logic [4:0]    ochnl_idx;
  logic          busy, done;

  conv_seq dut (
    .clk(clk), .rst(rst), .start(start), .num_knls(num_knls), .ifmap_w(ifmap_w),
    .first_chnl(first_chnl), .knl_base(knl_base), .ifmap_base(ifmap_base),
    .ofmap_base(ofmap_base), .dram_valid(dram_valid), .addr_rd(addr_rd), .addr_wr(addr_wr),
    .dram_en_rd(dram_en_rd), .dram_en_wr(dram_en_wr), .en_ld_knl(en_ld_knl),
    .en_ld_ifmap(en_ld_ifmap), .disable_acc(disable_acc), .ochnl_idx(ochnl_idx),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [AW-1:0] rd_q[$];
  logic [AW-1:0] wr_a[$];
  logic [4:0]    wr_ch[$];
  logic          wr_dacc[$];
  logic          wr_vld[$];
  int kl_cnt, wl_cnt, viol, done_cnt, bad_dacc, busy_bad;
  int lat_lo = 1;
  int lat_hi = 1;
  bit spur_on = 1'b0;
  bit pend = 1'b0;
  int cnt = 0;

  // DRAM responder and monitor: inputs change at negedge, combinational outputs sampled 1ns later.
  initial begin
    dram_valid = 1'b0;
    forever begin
      @(negedge clk);
      dram_valid = 1'b0;
      if (rst) begin
        pend = 1'b0;
      end else begin
        if (dram_en_rd) begin
          if (pend) viol++;
          pend = 1'b1;
          cnt = int'($urandom_range(lat_hi, lat_lo));
          rd_q.push_back(addr_rd);
        end
        if (pend) begin
          if (cnt == 0) begin
            dram_valid = 1'b1;
            pend = 1'b0;
          end else begin
            cnt--;
          end
        end else if (spur_on && $urandom_range(1, 0) == 1) begin
          dram_valid = 1'b1;
        end
      end
      #1;
      if (en_ld_knl) kl_cnt++;
      if (en_ld_ifmap) wl_cnt++;
      if (dram_en_wr) begin
        wr_a.push_back(addr_wr);
        wr_ch.push_back(ochnl_idx);
        wr_dacc.push_back(disable_acc);
        wr_vld.push_back(dram_valid);
      end else if (disable_acc) begin
        bad_dacc++;
      end
      if (done) begin
        done_cnt++;
        if (busy) busy_bad++;
      end
    end
  end

  task automatic clear_rec();
    rd_q.delete(); wr_a.delete(); wr_ch.delete(); wr_dacc.delete(); wr_vld.delete();
    kl_cnt = 0; wl_cnt = 0; viol = 0; done_cnt = 0; bad_dacc = 0; busy_bad = 0;
  endtask

  task automatic start_job(input int nk, input int w, input bit first);
    @(negedge clk);
    #2;
    num_knls = 6'(nk);
    ifmap_w = 6'(w);
    first_chnl = first;
    start = 1'b1;
    @(negedge clk);
    #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #3;
      if (done_cnt != 0) break;
    end
    repeat (3) @(negedge clk);
    #3;
    checks++;
    if (done_cnt !== 1 || busy_bad !== 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s done: pulses=%0d busy_at_done=%0d busy=%0b, need pulses=1 busy_at_done=0 busy=0",
               name, done_cnt, busy_bad, busy);
    end
  endtask

  task automatic check_job(input string name, input int nk, input int w, input bit first);
    logic [AW-1:0] er[$];
    logic [AW-1:0] ew[$];
    logic [4:0]    ec[$];
    logic [AW-1:0] ga, ea;
    int wo, idx, n, bad;
    wo = w - 4;
    for (int i = 0; i < 25 * nk; i++) er.push_back(knl_base + AW'(i));
    for (int oy = 0; oy < wo; oy++)
      for (int ox = 0; ox < wo; ox++) begin
        for (int c = 0; c < 5; c++)
          for (int r = 0; r < 5; r++) er.push_back(ifmap_base + AW'((oy + r) * w + ox + c));
        for (int k = 0; k < nk; k++) begin
          ea = ofmap_base + AW'(k * wo * wo + oy * wo + ox);
          if (!first) er.push_back(ea);
          ew.push_back(ea);
          ec.push_back(5'(k));
        end
      end

    idx = -1;
    n = (rd_q.size() < er.size()) ? rd_q.size() : er.size();
    for (int i = 0; i < n; i++) if (rd_q[i] !== er[i]) begin idx = i; break; end
    if (idx < 0 && rd_q.size() != er.size()) idx = n;
    checks++;
    if (idx >= 0) begin
      failures++;
      ga = (idx < rd_q.size()) ? rd_q[idx] : 'x;
      ea = (idx < er.size()) ? er[idx] : 'x;
      $display("FAIL %s rd_seq: reads=%0d need=%0d, at %0d got %h need %h", name, rd_q.size(), er.size(), idx, ga, ea);
    end

    idx = -1;
    n = (wr_a.size() < ew.size()) ? wr_a.size() : ew.size();
    for (int i = 0; i < n; i++) if (wr_a[i] !== ew[i] || wr_ch[i] !== ec[i]) begin idx = i; break; end
    if (idx < 0 && wr_a.size() != ew.size()) idx = n;
    checks++;
    if (idx >= 0) begin
      failures++;
      ga = (idx < wr_a.size()) ? wr_a[idx] : 'x;
      ea = (idx < ew.size()) ? ew[idx] : 'x;
      $display("FAIL %s wr_seq: writes=%0d need=%0d, at %0d got %h need %h", name, wr_a.size(), ew.size(), idx, ga, ea);
    end

    bad = 0;
    for (int i = 0; i < wr_dacc.size(); i++)
      if (wr_dacc[i] !== first || (!first && wr_vld[i] !== 1'b1)) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s wr_attr: %0d writes with wrong disable_acc/valid, need 0", name, bad);
    end
    checks++;
    if (kl_cnt != 25 * nk) begin
      failures++;
      $display("FAIL %s en_ld_knl: got %0d need %0d", name, kl_cnt, 25 * nk);
    end
    checks++;
    if (wl_cnt != 25 * wo * wo) begin
      failures++;
      $display("FAIL %s en_ld_ifmap: got %0d need %0d", name, wl_cnt, 25 * wo * wo);
    end
    checks++;
    if (viol != 0 || bad_dacc != 0) begin
      failures++;
      $display("FAIL %s protocol: overlapping reads=%0d stray disable_acc=%0d, need 0/0", name, viol, bad_dacc);
    end
  endtask

  task automatic run_job(input string name, input int nk, input int w, input bit first);
    clear_rec();
    start_job(nk, w, first);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL %s busy_after_start: got %0b need 1", name, busy);
    end
    wait_done(name, 20000);
    check_job(name, nk, w, first);
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({addr_rd, addr_wr, dram_en_rd, dram_en_wr, en_ld_knl, en_ld_ifmap, disable_acc, ochnl_idx, busy, done} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: addr_rd=%h addr_wr=%h en_rd=%0b busy=%0b done=%0b, need all 0",
               addr_rd, addr_wr, dram_en_rd, busy, done);
    end
    @(negedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [AW-1:0] exp_win[6];
    run_job("single", 1, 5, 1'b1);
    exp_win = '{18'h01000, 18'h01005, 18'h0100A, 18'h0100F, 18'h01014, 18'h01001};
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (rd_q.size() <= 25 + i || rd_q[25 + i] !== exp_win[i]) begin
        failures++;
        $display("FAIL single win_order[%0d]: got %h need %h", i, (rd_q.size() > 25 + i) ? rd_q[25 + i] : 'x, exp_win[i]);
      end
    end
  endtask

  task automatic test_full();
    run_job("full", 16, 6, 1'b0);
    checks++;
    if (wr_a.size() != 64 || wr_a[51] !== 18'h0200F || wr_ch[51] !== 5'd3) begin
      failures++;
      $display("FAIL full pix11_k3: writes=%0d addr=%h ch=%0d, need 64 02000f 3",
               wr_a.size(), (wr_a.size() > 51) ? wr_a[51] : 'x, (wr_ch.size() > 51) ? wr_ch[51] : 'x);
    end
  endtask

  task automatic test_random_lat();
    lat_lo = 0;
    lat_hi = 7;
    run_job("rand_lat", 3, 7, 1'b0);
    lat_lo = 1;
    lat_hi = 1;
  endtask

  task automatic test_busy_start();
    clear_rec();
    spur_on = 1'b1;
    start_job(2, 6, 1'b1);
    repeat (40) @(negedge clk);
    #2;
    num_knls = 6'd5;
    ifmap_w = 6'd9;
    start = 1'b1;
    @(negedge clk);
    #2;
    start = 1'b0;
    wait_done("busy_start", 20000);
    spur_on = 1'b0;
    check_job("busy_start", 2, 6, 1'b1);
  endtask

  task automatic test_mid_reset();
    clear_rec();
    start_job(2, 5, 1'b1);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      #3;
      if (wl_cnt >= 3) break;
    end
    rst = 1'b1;
    #1;
    checks++;
    if (wl_cnt < 3 || {addr_rd, addr_wr, dram_en_rd, dram_en_wr, en_ld_knl, en_ld_ifmap, disable_acc, ochnl_idx, busy, done} !== '0) begin
      failures++;
      $display("FAIL mid_reset_outputs: win_loads=%0d addr_rd=%h en_rd=%0b en_ld_ifmap=%0b busy=%0b, need >=3 and all 0",
               wl_cnt, addr_rd, dram_en_rd, en_ld_ifmap, busy);
    end
    @(negedge clk);
    #2;
    rst = 1'b0;
    run_job("after_reset", 2, 5, 1'b1);
    checks++;
    if (rd_q.size() == 0 || rd_q[0] !== knl_base) begin
      failures++;
      $display("FAIL after_reset first_read: got %h need %h", (rd_q.size() > 0) ? rd_q[0] : 'x, knl_base);
    end
  endtask

  task automatic test_reject();
    int nks[3] = '{0, 4, 17};
    int ws[3] = '{6, 4, 6};
    for (int t = 0; t < 3; t++) begin
      clear_rec();
      start_job(nks[t], ws[t], 1'b0);
      checks++;
      if (done !== 1'b1) begin
        failures++;
        $display("FAIL reject%0d done_pulse: got %0b need 1", t, done);
      end
      @(negedge clk);
      #2;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || rd_q.size() != 0 || wr_a.size() != 0) begin
        failures++;
        $display("FAIL reject%0d after: done=%0b busy=%0b reads=%0d writes=%0d, need 0 0 0 0",
                 t, done, busy, rd_q.size(), wr_a.size());
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    num_knls = '0;
    ifmap_w = '0;
    first_chnl = 1'b0;
    knl_base = 18'h00100;
    ifmap_base = 18'h01000;
    ofmap_base = 18'h02000;
    clear_rec();
    test_reset();
    test_single();
    test_full();
    test_random_lat();
    test_busy_start();
    test_mid_reset();
    test_reject();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
